// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the instruction fetch requester
// and the load/store data requester. Round-robin on ties, registered
// downstream request, zero-bubble back-to-back grants and an optional
// watchdog that aborts an access the memory never completes.
module mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  imem_valid_i,
  output logic                  imem_ready_o,
  input  logic [ADDR_WIDTH-1:0] imem_addr_i,
  input  logic [DATA_WIDTH-1:0] imem_wdata_i,
  input  logic [3:0]            imem_we_i,
  output logic [DATA_WIDTH-1:0] imem_rdata_o,
  input  logic                  dmem_valid_i,
  output logic                  dmem_ready_o,
  input  logic [ADDR_WIDTH-1:0] dmem_addr_i,
  input  logic [DATA_WIDTH-1:0] dmem_wdata_i,
  input  logic [3:0]            dmem_we_i,
  output logic [DATA_WIDTH-1:0] dmem_rdata_o,
  output logic                  mem_valid_o,
  input  logic                  mem_ready_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [3:0]            mem_we_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  err_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } state_t;

  // Counter wide enough to hold TIMEOUT_CYCLES; one bit when the watchdog is off.
  localparam int              CNT_W       = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
  localparam bit              WD_EN       = (TIMEOUT_CYCLES > 0);

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic                    last_d_r;     // 1: dmem was granted last, 0: imem
  logic                    mem_valid_r;
  logic [ADDR_WIDTH-1:0]   mem_addr_r;
  logic [DATA_WIDTH-1:0]   mem_wdata_r;
  logic [3:0]              mem_we_r;
  logic [CNT_W-1:0]        cnt_r;
  logic                    abort_r;      // high for the single abort cycle
  logic                    load_i_s;
  logic                    load_d_s;
  logic                    busy_s;
  logic                    mem_done_s;
  logic                    abort_nxt_s;
  logic                    cnt_en_s;

  assign busy_s     = (state_r != ST_IDLE);
  // A memory completion only counts while our request is actually presented.
  assign mem_done_s = mem_ready_i & mem_valid_r;
  // Abort is scheduled on the edge where the wait counter reaches the limit.
  assign abort_nxt_s = WD_EN & busy_s & ~abort_r & ~mem_ready_i &
                       (cnt_r == (TIMEOUT_VAL - CNT_W'(1)));
  assign cnt_en_s    = WD_EN & busy_s & ~mem_ready_i & (cnt_r != TIMEOUT_VAL);

  // Next-state and grant selection.
  always_comb begin
    state_nxt_s = state_r;
    load_i_s    = 1'b0;
    load_d_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (imem_valid_i && dmem_valid_i) begin
          if (last_d_r) begin
            load_i_s = 1'b1;
          end else begin
            load_d_s = 1'b1;
          end
        end else if (imem_valid_i) begin
          load_i_s = 1'b1;
        end else if (dmem_valid_i) begin
          load_d_s = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY_I: begin
        if (abort_r) begin
          state_nxt_s = ST_IDLE;
        end else if (mem_done_s) begin
          // imem_valid_i here belongs to the finished request; only dmem may follow.
          if (dmem_valid_i) begin
            load_d_s = 1'b1;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_BUSY_I;
        end
      end
      ST_BUSY_D: begin
        if (abort_r) begin
          state_nxt_s = ST_IDLE;
        end else if (mem_done_s) begin
          if (imem_valid_i) begin
            load_i_s = 1'b1;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_BUSY_D;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    if (load_i_s) begin
      state_nxt_s = ST_BUSY_I;
    end else if (load_d_s) begin
      state_nxt_s = ST_BUSY_D;
    end else begin
      state_nxt_s = state_nxt_s;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Downstream request registers, grant history and watchdog counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid_r <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      mem_we_r    <= 4'b0000;
      last_d_r    <= 1'b0;
      cnt_r       <= '0;
      abort_r     <= 1'b0;
    end else begin
      abort_r <= abort_nxt_s;
      if (load_i_s) begin
        mem_valid_r <= 1'b1;
        mem_addr_r  <= imem_addr_i;
        mem_wdata_r <= imem_wdata_i;
        mem_we_r    <= imem_we_i;
        last_d_r    <= 1'b0;
        cnt_r       <= '0;
      end else if (load_d_s) begin
        mem_valid_r <= 1'b1;
        mem_addr_r  <= dmem_addr_i;
        mem_wdata_r <= dmem_wdata_i;
        mem_we_r    <= dmem_we_i;
        last_d_r    <= 1'b1;
        cnt_r       <= '0;
      end else if (state_nxt_s == ST_IDLE) begin
        mem_valid_r <= 1'b0;
        cnt_r       <= '0;
      end else if (cnt_en_s) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Completion is forwarded combinationally; an abort completes with zero data.
  assign imem_ready_o = (state_r == ST_BUSY_I) & (mem_done_s | abort_r);
  assign dmem_ready_o = (state_r == ST_BUSY_D) & (mem_done_s | abort_r);
  assign imem_rdata_o = abort_r ? '0 : mem_rdata_i;
  assign dmem_rdata_o = abort_r ? '0 : mem_rdata_i;
  assign mem_valid_o  = mem_valid_r;
  assign mem_addr_o   = mem_addr_r;
  assign mem_wdata_o  = mem_wdata_r;
  assign mem_we_o     = mem_we_r;
  assign err_o        = abort_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios with literal expectations plus
// a randomized run, all checked every cycle against a transaction-level model.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  // main instance (watchdog disabled)
  logic        imem_valid_i, imem_ready_o, dmem_valid_i, dmem_ready_o;
  logic [31:0] imem_addr_i, imem_wdata_i, imem_rdata_o;
  logic [31:0] dmem_addr_i, dmem_wdata_i, dmem_rdata_o;
  logic [3:0]  imem_we_i, dmem_we_i, mem_we_o;
  logic        mem_valid_o, mem_ready_i, err_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  // watchdog instance (TIMEOUT_CYCLES=4)
  logic        w_imem_valid, w_imem_ready, w_dmem_valid, w_dmem_ready;
  logic [31:0] w_imem_addr, w_imem_wdata, w_imem_rdata;
  logic [31:0] w_dmem_addr, w_dmem_wdata, w_dmem_rdata;
  logic [3:0]  w_imem_we, w_dmem_we, w_mem_we;
  logic        w_mem_valid, w_mem_ready, w_err;
  logic [31:0] w_mem_addr, w_mem_wdata, w_mem_rdata;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_valid_i(imem_valid_i), .imem_ready_o(imem_ready_o), .imem_addr_i(imem_addr_i),
    .imem_wdata_i(imem_wdata_i), .imem_we_i(imem_we_i), .imem_rdata_o(imem_rdata_o),
    .dmem_valid_i(dmem_valid_i), .dmem_ready_o(dmem_ready_o), .dmem_addr_i(dmem_addr_i),
    .dmem_wdata_i(dmem_wdata_i), .dmem_we_i(dmem_we_i), .dmem_rdata_o(dmem_rdata_o),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o), .mem_rdata_i(mem_rdata_i), .err_o(err_o)
  );

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) u_wd (
    .clk(clk), .rst_n(rst_n),
    .imem_valid_i(w_imem_valid), .imem_ready_o(w_imem_ready), .imem_addr_i(w_imem_addr),
    .imem_wdata_i(w_imem_wdata), .imem_we_i(w_imem_we), .imem_rdata_o(w_imem_rdata),
    .dmem_valid_i(w_dmem_valid), .dmem_ready_o(w_dmem_ready), .dmem_addr_i(w_dmem_addr),
    .dmem_wdata_i(w_dmem_wdata), .dmem_we_i(w_dmem_we), .dmem_rdata_o(w_dmem_rdata),
    .mem_valid_o(w_mem_valid), .mem_ready_i(w_mem_ready), .mem_addr_o(w_mem_addr),
    .mem_wdata_o(w_mem_wdata), .mem_we_o(w_mem_we), .mem_rdata_i(w_mem_rdata), .err_o(w_err)
  );

  int total = 0;
  int bad   = 0;

  // Model: who owns the memory port (0 none, 1 imem, 2 dmem), who won last,
  // and the fields of the transaction currently presented downstream.
  int          m_owner;
  int          m_last;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_we;
  logic        i_seen, d_seen;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_last = 1; m_addr = '0; m_wdata = '0; m_we = '0;
  endtask

  task automatic grant(input int s);
    m_owner = s;
    m_last  = s;
    if (s == 1) begin
      m_addr = imem_addr_i; m_wdata = imem_wdata_i; m_we = imem_we_i;
    end else begin
      m_addr = dmem_addr_i; m_wdata = dmem_wdata_i; m_we = dmem_we_i;
    end
  endtask

  task automatic model_check();
    chk("mem_valid", mem_valid_o, m_owner != 0);
    chk("mem_addr", mem_addr_o, m_addr);
    chk("mem_wdata", mem_wdata_o, m_wdata);
    chk("mem_we", mem_we_o, m_we);
    chk("imem_ready", imem_ready_o, (m_owner == 1) && mem_ready_i);
    chk("dmem_ready", dmem_ready_o, (m_owner == 2) && mem_ready_i);
    if (m_owner == 1 && mem_ready_i) chk("imem_rdata", imem_rdata_o, mem_rdata_i);
    if (m_owner == 2 && mem_ready_i) chk("dmem_rdata", dmem_rdata_o, mem_rdata_i);
    chk("err", err_o, 1'b0);
  endtask

  // Advance the model by one clock edge using the inputs present before it.
  task automatic model_step();
    int other;
    if (m_owner == 0) begin
      if (imem_valid_i && dmem_valid_i) grant(m_last == 1 ? 2 : 1);
      else if (imem_valid_i) grant(1);
      else if (dmem_valid_i) grant(2);
    end else if (mem_ready_i) begin
      other = 3 - m_owner;
      if ((other == 1) ? imem_valid_i : dmem_valid_i) grant(other);
      else m_owner = 0;
    end
  endtask

  // One clock: compare at the falling edge, step the model, return 1 after the rise.
  task automatic cycle();
    @(negedge clk);
    model_check();
    i_seen = imem_ready_o;
    d_seen = dmem_ready_o;
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    imem_valid_i = 1'b0; imem_addr_i = '0; imem_wdata_i = '0; imem_we_i = 4'h0;
    dmem_valid_i = 1'b0; dmem_addr_i = '0; dmem_wdata_i = '0; dmem_we_i = 4'h0;
    mem_ready_i = 1'b0; mem_rdata_i = '0;
    w_imem_valid = 1'b0; w_imem_addr = '0; w_imem_wdata = '0; w_imem_we = 4'h0;
    w_dmem_valid = 1'b0; w_dmem_addr = '0; w_dmem_wdata = '0; w_dmem_we = 4'h0;
    w_mem_ready = 1'b0; w_mem_rdata = '0;
    i_seen = 1'b0; d_seen = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    chk("rst_mem_valid", mem_valid_o, 1'b0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    chk("rst_mem_wdata", mem_wdata_o, 32'h0);
    chk("rst_mem_we", mem_we_o, 4'h0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_w_valid", w_mem_valid, 1'b0);

    // Simultaneous request right after reset: dmem wins, imem follows with no gap
    imem_valid_i = 1'b1; imem_addr_i = 32'h0;    imem_we_i = 4'h0; imem_wdata_i = 32'h0;
    dmem_valid_i = 1'b1; dmem_addr_i = 32'h2000; dmem_we_i = 4'hF; dmem_wdata_i = 32'h12345678;
    #1 chk("tie_not_yet", mem_valid_o, 1'b0);
    cycle();
    chk("tie_d_addr", mem_addr_o, 32'h2000);
    chk("tie_d_we", mem_we_o, 4'hF);
    chk("tie_d_wdata", mem_wdata_o, 32'h12345678);
    mem_ready_i = 1'b1; mem_rdata_i = 32'h0BAD0BAD;
    #1 chk("tie_d_ready", dmem_ready_o, 1'b1);
    cycle();
    dmem_valid_i = 1'b0;
    #1;
    chk("tie_i_valid", mem_valid_o, 1'b1);
    chk("tie_i_addr", mem_addr_o, 32'h0);
    chk("tie_i_we", mem_we_o, 4'h0);
    chk("tie_i_ready", imem_ready_o, 1'b1);
    cycle();
    imem_valid_i = 1'b0; mem_ready_i = 1'b0;
    cycle();

    // Single fetch with memory ready in the second busy cycle
    imem_valid_i = 1'b1; imem_addr_i = 32'h100;
    cycle();
    chk("fetch_valid", mem_valid_o, 1'b1);
    chk("fetch_addr", mem_addr_o, 32'h100);
    cycle();
    mem_ready_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
    #1;
    chk("fetch_ready", imem_ready_o, 1'b1);
    chk("fetch_rdata", imem_rdata_o, 32'hDEADBEEF);
    chk("fetch_dready", dmem_ready_o, 1'b0);
    cycle();
    imem_valid_i = 1'b0; mem_ready_i = 1'b0;
    #1 chk("fetch_idle", mem_valid_o, 1'b0);

    // Continuous contention, ready every cycle: D,I,D,I,D,I without a bubble
    imem_valid_i = 1'b1; imem_addr_i = 32'h1000;
    dmem_valid_i = 1'b1; dmem_addr_i = 32'h3000; dmem_we_i = 4'h0;
    mem_ready_i = 1'b1;
    cycle();
    for (int k = 0; k < 6; k++) begin
      mem_rdata_i = $urandom();
      #1;
      chk("fair_i", imem_ready_o, (k % 2) == 1);
      chk("fair_d", dmem_ready_o, (k % 2) == 0);
      chk("fair_valid", mem_valid_o, 1'b1);
      cycle();
      if ((k % 2) == 0) begin
        if (k >= 4) dmem_valid_i = 1'b0; else dmem_addr_i = dmem_addr_i + 32'h4;
      end else begin
        if (k >= 4) imem_valid_i = 1'b0; else imem_addr_i = imem_addr_i + 32'h4;
      end
    end
    mem_ready_i = 1'b0;
    #1 chk("fair_end_idle", mem_valid_o, 1'b0);
    cycle();

    // Held stability: dmem waits while imem access stalls 5 cycles
    imem_valid_i = 1'b1; imem_addr_i = 32'h300;
    cycle();
    dmem_valid_i = 1'b1; dmem_addr_i = 32'h400; dmem_we_i = 4'h3; dmem_wdata_i = 32'hAA;
    for (int w = 0; w < 5; w++) begin
      #1;
      chk("hold_addr", mem_addr_o, 32'h300);
      chk("hold_dready", dmem_ready_o, 1'b0);
      cycle();
    end
    mem_ready_i = 1'b1;
    #1 chk("hold_iready", imem_ready_o, 1'b1);
    cycle();
    imem_valid_i = 1'b0;
    #1;
    chk("hold_switch_addr", mem_addr_o, 32'h400);
    chk("hold_switch_valid", mem_valid_o, 1'b1);
    chk("hold_dready_now", dmem_ready_o, 1'b1);
    cycle();
    dmem_valid_i = 1'b0; mem_ready_i = 1'b0;
    cycle();

    // Watchdog instance: memory never ready, abort after 4 busy cycles
    w_imem_valid = 1'b1; w_imem_addr = 32'h40; w_mem_rdata = 32'hFFFFFFFF;
    cycle();
    for (int c = 0; c < 4; c++) begin
      chk("wd_valid", w_mem_valid, 1'b1);
      chk("wd_addr", w_mem_addr, 32'h40);
      chk("wd_no_ready", w_imem_ready, 1'b0);
      chk("wd_no_err", w_err, 1'b0);
      cycle();
    end
    chk("wd_ready", w_imem_ready, 1'b1);
    chk("wd_rdata", w_imem_rdata, 32'h0);
    chk("wd_err", w_err, 1'b1);
    chk("wd_dready", w_dmem_ready, 1'b0);
    cycle();
    w_imem_valid = 1'b0;
    chk("wd_err_pulse", w_err, 1'b0);
    chk("wd_dropped", w_mem_valid, 1'b0);
    w_mem_ready = 1'b1;
    #1;
    chk("wd_spurious_i", w_imem_ready, 1'b0);
    chk("wd_spurious_d", w_dmem_ready, 1'b0);
    cycle();
    chk("wd_still_idle", w_mem_valid, 1'b0);
    w_mem_ready = 1'b0;

    // Randomized traffic obeying the requester contract
    for (int n = 0; n < 2000; n++) begin
      cycle();
      if (imem_valid_i && i_seen) begin
        if ($urandom_range(0, 1) == 0) imem_valid_i = 1'b0;
        else begin
          imem_addr_i = $urandom(); imem_wdata_i = $urandom(); imem_we_i = 4'($urandom_range(0, 15));
        end
      end else if (!imem_valid_i && $urandom_range(0, 2) == 0) begin
        imem_valid_i = 1'b1;
        imem_addr_i = $urandom(); imem_wdata_i = $urandom(); imem_we_i = 4'($urandom_range(0, 15));
      end
      if (dmem_valid_i && d_seen) begin
        if ($urandom_range(0, 1) == 0) dmem_valid_i = 1'b0;
        else begin
          dmem_addr_i = $urandom(); dmem_wdata_i = $urandom(); dmem_we_i = 4'($urandom_range(0, 15));
        end
      end else if (!dmem_valid_i && $urandom_range(0, 2) == 0) begin
        dmem_valid_i = 1'b1;
        dmem_addr_i = $urandom(); dmem_wdata_i = $urandom(); dmem_we_i = 4'($urandom_range(0, 15));
      end
      mem_ready_i = ($urandom_range(0, 2) == 0);
      mem_rdata_i = $urandom();
    end
    imem_valid_i = 1'b0; dmem_valid_i = 1'b0; mem_ready_i = 1'b1;
    cycle();
    mem_ready_i = 1'b0;
    cycle();
    cycle();

    // Reset in the middle of a dmem access, then first tie goes to dmem
    dmem_valid_i = 1'b1; dmem_addr_i = 32'h500; dmem_we_i = 4'h1;
    cycle();
    chk("mid_busy", mem_valid_o, 1'b1);
    rst_n = 1'b0;
    #1 chk("mid_async_drop", mem_valid_o, 1'b0);
    dmem_valid_i = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    imem_valid_i = 1'b1; imem_addr_i = 32'h600; imem_we_i = 4'h0;
    dmem_valid_i = 1'b1; dmem_addr_i = 32'h700; dmem_we_i = 4'hC;
    cycle();
    chk("post_rst_d_addr", mem_addr_o, 32'h700);
    chk("post_rst_d_we", mem_we_o, 4'hC);
    mem_ready_i = 1'b1;
    cycle();
    dmem_valid_i = 1'b0;
    chk("post_rst_i_addr", mem_addr_o, 32'h600);
    cycle();
    imem_valid_i = 1'b0; mem_ready_i = 1'b0;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
